// File: rtl/idu_skid_stage.sv
// rtl/idu_skid_stage.sv - decode-to-execute register with 2-entry skid buffer and writeback forwarding
module idu_skid_stage #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 32,
  parameter int NFWD   = 2,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [31:0]            in_instr,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [XLEN-1:0]        in_rs1_data,
  input  logic [XLEN-1:0]        in_rs2_data,
  input  logic [NFWD-1:0]        fwd_en,
  input  logic [NFWD*5-1:0]      fwd_idx,
  input  logic [NFWD*XLEN-1:0]   fwd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [31:0]            out_instr,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [XLEN-1:0]        out_rs1_data,
  output logic [XLEN-1:0]        out_rs2_data,
  output logic [CNT_W-1:0]       stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [31:0]       instr;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
  } entry_t;

  entry_t            main_q, main_d, skid_q, skid_d;
  entry_t            main_cur, skid_cur, in_cur;
  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              acc_in, acc_out;

  // Lowest-numbered matching port wins; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]           idx,
    input logic [XLEN-1:0]      d,
    input logic [NFWD-1:0]      en,
    input logic [NFWD*5-1:0]    fidx,
    input logic [NFWD*XLEN-1:0] fdat
  );
    logic [XLEN-1:0] r;
    r = d;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (en[i] && (fidx[5*i +: 5] == idx) && (idx != 5'd0)) r = fdat[XLEN*i +: XLEN];
    end
    return r;
  endfunction

  function automatic entry_t refresh(
    input entry_t               e,
    input logic [NFWD-1:0]      en,
    input logic [NFWD*5-1:0]    fidx,
    input logic [NFWD*XLEN-1:0] fdat
  );
    entry_t r;
    r     = e;
    r.rs1 = fwd_sel(e.instr[19:15], e.rs1, en, fidx, fdat);
    r.rs2 = fwd_sel(e.instr[24:20], e.rs2, en, fidx, fdat);
    return r;
  endfunction

  assign acc_in  = in_valid & in_ready_q;
  assign acc_out = main_valid_q & out_ready;

  always_comb begin
    in_cur       = refresh('{pc: in_pc, instr: in_instr, ctrl: in_ctrl,
                             rs1: in_rs1_data, rs2: in_rs2_data}, fwd_en, fwd_idx, fwd_data);
    main_cur     = refresh(main_q, fwd_en, fwd_idx, fwd_data);
    skid_cur     = refresh(skid_q, fwd_en, fwd_idx, fwd_data);
    main_d       = main_cur;
    skid_d       = skid_cur;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || acc_out) begin
      // in_ready is low whenever skid is occupied, so skid promotion never races an input.
      if (skid_valid_q) begin
        main_d       = skid_cur;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = acc_in;
        if (acc_in) main_d = in_cur;
      end
    end else if (acc_in) begin
      skid_d       = in_cur;
      skid_valid_d = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (main_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      stall_q      <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
      stall_q      <= stall_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = main_valid_q;
  assign out_pc       = main_q.pc;
  assign out_instr    = main_q.instr;
  assign out_ctrl     = main_q.ctrl;
  assign out_rs1_data = main_q.rs1;
  assign out_rs2_data = main_q.rs2;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_idu_skid_stage.sv
// tb/tb_idu_skid_stage.sv - scoreboard bench for idu_skid_stage
module tb_idu_skid_stage;
  localparam int XLEN   = 64;
  localparam int CTRL_W = 32;
  localparam int NFWD   = 2;
  localparam int CNT_W  = 4;

  logic                 clk, rstn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0]      in_pc, in_rs1_data, in_rs2_data;
  logic [31:0]          in_instr, out_instr;
  logic [CTRL_W-1:0]    in_ctrl, out_ctrl;
  logic [NFWD-1:0]      fwd_en;
  logic [NFWD*5-1:0]    fwd_idx;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic [XLEN-1:0]      out_pc, out_rs1_data, out_rs2_data;
  logic [CNT_W-1:0]     stall_cnt;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [31:0]       instr;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
  } ent_t;

  ent_t             sb[$];
  int               n_cmp, n_bad;
  logic [CNT_W-1:0] m_stall;

  idu_skid_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_ctrl(in_ctrl),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .fwd_en(fwd_en), .fwd_idx(fwd_idx), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_ctrl(out_ctrl), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] bf(input logic [4:0] idx, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    r = d;
    if (idx != 5'd0) begin
      if (fwd_en[1] && fwd_idx[9:5] == idx) r = fwd_data[127:64];
      if (fwd_en[0] && fwd_idx[4:0] == idx) r = fwd_data[63:0];
    end
    return r;
  endfunction

  task automatic set_in(input logic v, input logic [4:0] r1, input logic [4:0] r2, input int k);
    in_valid    = v;
    in_pc       = 64'h1000 + 64'(k) * 4;
    in_instr    = {7'h00, r2, r1, 3'b000, 5'd1, 7'h33};
    in_ctrl     = 32'hC000_0000 | 32'(k);
    in_rs1_data = 64'hA000 + 64'(k);
    in_rs2_data = 64'hB000 + 64'(k);
  endtask

  // Called at a negedge with inputs already driven; checks, updates the model, advances one cycle.
  task automatic cycle();
    logic a_in, a_out;
    ent_t n;
    #1;
    a_in  = in_valid && (sb.size() < 2);
    a_out = (sb.size() != 0) && out_ready;
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (sb.size() != 0) begin
      chk("out_pc", out_pc, sb[0].pc);
      chk("out_instr", 64'(out_instr), 64'(sb[0].instr));
      chk("out_ctrl", 64'(out_ctrl), 64'(sb[0].ctrl));
      chk("out_rs1", out_rs1_data, sb[0].rs1);
      chk("out_rs2", out_rs2_data, sb[0].rs2);
      if (!out_ready && m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1'b1;
    end
    if (a_out) void'(sb.pop_front());
    if (flush) sb.delete();
    else begin
      foreach (sb[i]) begin
        sb[i].rs1 = bf(sb[i].instr[19:15], sb[i].rs1);
        sb[i].rs2 = bf(sb[i].instr[24:20], sb[i].rs2);
      end
      if (a_in) begin
        n.pc = in_pc; n.instr = in_instr; n.ctrl = in_ctrl;
        n.rs1 = bf(in_instr[19:15], in_rs1_data);
        n.rs2 = bf(in_instr[24:20], in_rs2_data);
        sb.push_back(n);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    set_in(1'b0, 5'd0, 5'd0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) cycle();
    chk("drain_left", 64'(sb.size()), 64'd0);
    cycle();
  endtask

  initial begin
    int k;
    n_cmp = 0; n_bad = 0; m_stall = '0;
    rstn = 1'b0; flush = 1'b0; out_ready = 1'b0;
    fwd_en = '0; fwd_idx = '0; fwd_data = '0;
    set_in(1'b0, 5'd0, 5'd0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 5'd1, 5'd2, i);
      cycle();
    end
    drain();

    // back-pressure fills main then skid
    out_ready = 1'b0;
    k = 10;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 5'd3, 5'd4, k);
      if (sb.size() < 2) begin cycle(); k++; end else cycle();
    end
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    drain();

    // forwarding onto a held operand
    out_ready = 1'b0;
    set_in(1'b1, 5'd5, 5'd6, 20);
    cycle();
    set_in(1'b0, 5'd0, 5'd0, 0);
    fwd_en = 2'b10; fwd_idx = {5'd5, 5'd0}; fwd_data = {64'hDEAD, 64'h0};
    cycle();
    fwd_en = '0;
    chk("held_fwd_rs1", out_rs1_data, 64'hDEAD);
    drain();

    // port priority and x0 exclusion at capture
    out_ready = 1'b1;
    fwd_en = 2'b11; fwd_idx = {5'd7, 5'd7}; fwd_data = {64'h22, 64'h11};
    set_in(1'b1, 5'd0, 5'd7, 30);
    cycle();
    chk("prio_rs2", out_rs2_data, 64'h11);
    chk("x0_rs1", out_rs1_data, 64'hA000 + 64'd30);
    fwd_idx = {5'd0, 5'd0};
    set_in(1'b1, 5'd0, 5'd0, 31);
    cycle();
    fwd_en = '0;
    drain();

    // flush with both entries occupied and input offered
    out_ready = 1'b0;
    set_in(1'b1, 5'd8, 5'd9, 40); cycle();
    set_in(1'b1, 5'd8, 5'd9, 41); cycle();
    set_in(1'b1, 5'd8, 5'd9, 42);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    set_in(1'b0, 5'd0, 5'd0, 0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) cycle();

    // stall counter saturation
    out_ready = 1'b0;
    set_in(1'b1, 5'd1, 5'd1, 50); cycle();
    set_in(1'b0, 5'd0, 5'd0, 0);
    repeat (20) cycle();
    chk("stall_sat", 64'(stall_cnt), 64'hF);

    // asynchronous reset between edges mid-stall
    set_in(1'b1, 5'd1, 5'd1, 51); cycle();
    #2 rstn = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_stall", 64'(stall_cnt), 64'd0);
    chk("arst_out_rs1", out_rs1_data, 64'd0);
    sb.delete();
    m_stall = '0;
    set_in(1'b0, 5'd0, 5'd0, 0);
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    set_in(1'b1, 5'd2, 5'd3, 60); cycle();
    set_in(1'b1, 5'd2, 5'd3, 61); cycle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
